// File: rtl/chunked_logic_unit.sv
// rtl/chunked_logic_unit.sv - multi-cycle chunked bitwise logic unit with zero/parity/op_err flags
module chunked_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             parity,
    output logic             op_err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;

    // One chunk of the selected operation; unsupported encodings yield zero.
    function automatic logic [CHUNK-1:0] chunk_op(input logic [2:0] sel,
                                                  input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y);
        case (sel)
            3'b000:  chunk_op = x & y;
            3'b001:  chunk_op = x | y;
            3'b010:  chunk_op = x ^ y;
            3'b011:  chunk_op = ~(x | y);
            3'b100:  chunk_op = ~(x ^ y);
            3'b101:  chunk_op = x & ~y;
            default: chunk_op = '0;
        endcase
    endfunction

    assign in_ready   = (state == IDLE);
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    // Merge the slice selected by the counter into the accumulator, so the
    // final edge can load the result registers from the completed value.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                acc_next[i*CHUNK +: CHUNK] = chunk_op(op_q, a_q[i*CHUNK +: CHUNK],
                                                      b_q[i*CHUNK +: CHUNK]);
            end
        end
    end

    // Control FSM with operand capture, chunk accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc       <= '0;
            res       <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
            op_err    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (last_chunk) begin
                        cnt       <= '0;
                        res       <= acc_next;
                        zero      <= ~|acc_next;
                        parity    <= ^acc_next;
                        op_err    <= op_q[2] & op_q[1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_logic_unit.sv
// tb/tb_chunked_logic_unit.sv - directed self-checking bench for chunked_logic_unit
module tb_chunked_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        zero;
    logic        parity;
    logic        op_err;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [15:0] n_a;
    logic [15:0] n_b;
    logic [2:0]  n_op;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [15:0] n_res;
    logic        n_zero;
    logic        n_parity;
    logic        n_op_err;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    chunked_logic_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .parity(parity), .op_err(op_err)
    );

    chunked_logic_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .op(n_op), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .res(n_res), .zero(n_zero), .parity(n_parity), .op_err(n_op_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one job, optionally keep in_valid high with junk afterwards,
    // and return at the negedge where out_valid is first seen (edges counted
    // from the accept edge as 1).
    task automatic issue(input logic [31:0] aa, input logic [31:0] bb,
                         input logic [2:0] oo, input bit keep_valid, output int l);
        @(negedge clk);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        a = aa; b = bb; op = oo; in_valid = 1'b1;
        @(posedge clk);
        l = 1;
        @(negedge clk);
        a = ~aa; b = ~bb; op = 3'b001;
        in_valid = keep_valid;
        if (keep_valid) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        while (!out_valid && l < 40) begin
            @(posedge clk);
            l++;
            @(negedge clk);
        end
        if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                             input logic [2:0] oo, input logic [31:0] er,
                             input logic ez, input logic ep, input logic ee);
        issue(aa, bb, oo, 1'b0, lat);
        check({tag, "_lat"}, lat, 32'd5);
        check({tag, "_res"}, res, er);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, "_parity"}, {31'd0, parity}, {31'd0, ep});
        check({tag, "_op_err"}, {31'd0, op_err}, {31'd0, ee});
        accept();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_a = '0; n_b = '0; n_op = '0; n_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_flags", {29'd0, zero, parity, op_err}, 32'd0);

        // Scenario 1 and 2: XOR patterns
        run_check("xor_allones", 32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_check("xor_zero",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_check("xor_mix",     32'h0003_FFFF, 32'hFFFF_FFFF, 3'b010, 32'hFFFC_0000, 1'b0, 1'b0, 1'b0);
        run_check("xor_odd",     32'h0000_0001, 32'h0000_0000, 3'b010, 32'h0000_0001, 1'b0, 1'b1, 1'b0);

        // Scenario 3: op sweep
        run_check("and",  32'h0003_FFFF, 32'h00FF_00FF, 3'b000, 32'h0003_00FF, 1'b0, 1'b0, 1'b0);
        run_check("or",   32'h0003_FFFF, 32'h00FF_00FF, 3'b001, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
        run_check("xor",  32'h0003_FFFF, 32'h00FF_00FF, 3'b010, 32'h00FC_FF00, 1'b0, 1'b0, 1'b0);
        run_check("nor",  32'h0003_FFFF, 32'h00FF_00FF, 3'b011, 32'hFF00_0000, 1'b0, 1'b0, 1'b0);
        run_check("xnor", 32'h0003_FFFF, 32'h00FF_00FF, 3'b100, 32'hFF03_00FF, 1'b0, 1'b0, 1'b0);
        run_check("andn", 32'h0003_FFFF, 32'h00FF_00FF, 3'b101, 32'h0000_FF00, 1'b0, 1'b0, 1'b0);
        run_check("and_odd", 32'h8000_0001, 32'h8000_0000, 3'b000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Scenario 4: unsupported ops
        run_check("op111", 32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_check("op110", 32'hFFFF_FFFF, 32'h0000_0000, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Scenario 5: hold in DONE, stray in_valid ignored during BUSY/DONE
        issue(32'h1234_5678, 32'h0F0F_0F0F, 3'b000, 1'b1, lat);
        check("hold_lat", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_res", res, 32'h0204_0608);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        accept();
        check("hold_res_kept", res, 32'h0204_0608);

        // out_ready held high before DONE: out_valid lasts exactly one cycle
        out_ready = 1'b1;
        issue(32'h0000_00FF, 32'h0000_0000, 3'b001, 1'b0, lat);
        check("pre_ready_lat", lat, 32'd5);
        check("pre_ready_res", res, 32'h0000_00FF);
        @(posedge clk);
        @(negedge clk);
        check("pre_ready_one_cycle", {31'd0, out_valid}, 32'd0);
        check("pre_ready_idle", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Scenario 6: reset in the 2nd BUSY cycle discards the job
        a = 32'hFFFF_FFFF; b = 32'h0; op = 3'b011; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_res", res, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        run_check("post_rst_xor", 32'h0000_00F0, 32'h0000_000F, 3'b010, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

        // Single-chunk variant: WIDTH=16, CHUNK=16
        @(negedge clk);
        check("w16_in_ready", {31'd0, n_in_ready}, 32'd1);
        n_a = 16'h0000; n_b = 16'hFFFF; n_op = 3'b010; n_in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        n_in_valid = 1'b0; n_a = 16'h5555;
        while (!n_out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!n_out_valid) check("w16_timeout", 32'd0, 32'd1);
        check("w16_lat", lat, 32'd2);
        check("w16_res", {16'd0, n_res}, 32'h0000_FFFF);
        check("w16_flags", {29'd0, n_zero, n_parity, n_op_err}, 32'd0);
        n_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_out_ready = 1'b0;
        check("w16_accept", {30'd0, n_out_valid, n_in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
